write_back_buf: RTL

Parametrised write-back stage for the RV32I_Zicsr pipeline. It selects the result source (ALU, formatted load data, PC+4, CSR read value) and performs load byte/half/word alignment and sign/zero extension. Retiring writes go into a DEPTH-entry buffer that drains to the register-file write port under a valid/ready handshake. It sits between the memory stage and the register file, and drives the pipeline stall and the retirement count.

---
 rtl/write_back_buf.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/write_back_buf.sv
// Write-back stage: selects the result source, formats loads, and queues retiring
// register writes in a DEPTH-entry buffer drained by a valid/ready register-file port.
// Optional retired-instruction counter on or_instret is enabled with `define WB_INSTRET_EN.
module write_back_buf #(
  parameter int XLEN  = 32,
  parameter int XADDR = 5,
  parameter int DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic                          i_flush,
  input  logic [1:0]                    i_src,
  input  logic [XADDR-1:0]              i_rd_addr,
  input  logic                          i_rd_write,
  input  logic [XLEN-1:0]               i_alu_data,
  input  logic [XLEN-1:0]               i_mem_data,
  input  logic [XLEN-1:0]               i_csr_data,
  input  logic [XLEN-1:0]               i_pc,
  input  logic [2:0]                    i_funct3,
  input  logic [$clog2(XLEN/8)-1:0]     i_addr_lo,
  input  logic                          i_rf_ready,
  output logic                          or_valid,
  output logic [XADDR-1:0]              or_rd_addr,
  output logic                          or_rd_write,
  output logic [XLEN-1:0]               or_rd_data,
  output logic                          or_stall
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]                   or_instret
`endif
);

  localparam int OFFW = $clog2(XLEN/8);
  localparam int SHW  = OFFW + 3;
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam bit WORD_EXT = (XLEN == 64);

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_LD  = 2'b01;
  localparam logic [1:0] SRC_PC4 = 2'b10;

  // ---------------------------------------------------------------
  // Load lane extraction
  // ---------------------------------------------------------------
  logic [SHW-1:0]  byte_sh;
  logic [SHW-1:0]  half_sh;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [31:0]     ld_w;
  logic [XLEN-1:0] ld_fmt;

  assign byte_sh = {i_addr_lo, 3'b000};
  // Halfword lane ignores the low offset bit, so misaligned offsets round down.
  assign half_sh = {i_addr_lo[OFFW-1:1], 4'b0000};
  assign ld_b    = i_mem_data[byte_sh +: 8];
  assign ld_h    = i_mem_data[half_sh +: 16];

  generate
    if (XLEN == 64) begin : g_word64
      assign ld_w = i_mem_data[{i_addr_lo[OFFW-1], 5'b00000} +: 32];
    end else begin : g_word32
      assign ld_w = i_mem_data[31:0];
    end
  endgenerate

  always_comb begin
    ld_fmt = i_mem_data;
    case (i_funct3)
      3'b000: ld_fmt = XLEN'($signed(ld_b));
      3'b100: ld_fmt = XLEN'(ld_b);
      3'b001: ld_fmt = XLEN'($signed(ld_h));
      3'b101: ld_fmt = XLEN'(ld_h);
      3'b010: if (WORD_EXT) ld_fmt = XLEN'($signed(ld_w));
      3'b110: if (WORD_EXT) ld_fmt = XLEN'(ld_w);
      default: ld_fmt = i_mem_data;
    endcase
  end

  // ---------------------------------------------------------------
  // Result select and entry formatting
  // ---------------------------------------------------------------
  logic [XLEN-1:0] push_data;
  logic            push_we;

  always_comb begin
    case (i_src)
      SRC_ALU: push_data = i_alu_data;
      SRC_LD:  push_data = ld_fmt;
      SRC_PC4: push_data = i_pc + XLEN'(4);
      default: push_data = i_csr_data;
    endcase
  end

  // x0 writes still occupy a slot and retire, but never reach the register file.
  assign push_we = i_rd_write && (i_rd_addr != '0);

  // ---------------------------------------------------------------
  // Retire buffer
  // ---------------------------------------------------------------
  logic [XLEN-1:0]  buf_data [DEPTH];
  logic [XADDR-1:0] buf_addr [DEPTH];
  logic             buf_we   [DEPTH];

  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CNTW-1:0] count;
  logic            head_we;

  logic            push_en;
  logic            pop_en;
  logic [CNTW-1:0] count_after_pop;
  logic [CNTW-1:0] count_nxt;
  logic [PTRW-1:0] rd_ptr_nxt;
  logic            load_head;
  logic            head_from_push;

  assign o_ready = (count != CNTW'(DEPTH));

  always_comb begin
    push_en         = i_valid && o_ready && !i_flush;
    pop_en          = or_valid && i_rf_ready && !i_flush;
    count_after_pop = count - CNTW'(pop_en);
    count_nxt       = count_after_pop + CNTW'(push_en);
    rd_ptr_nxt      = rd_ptr + PTRW'(pop_en);
    // Head registers move only when the head is consumed or the buffer fills from empty.
    load_head       = (count_nxt != '0) && (pop_en || (count == '0));
    head_from_push  = push_en && (count_after_pop == '0);
  end

  always_ff @(posedge i_clk) begin
    if (push_en) begin
      buf_data[wr_ptr] <= push_data;
      buf_addr[wr_ptr] <= i_rd_addr;
      buf_we[wr_ptr]   <= push_we;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      or_valid   <= 1'b0;
      or_stall   <= 1'b0;
      or_rd_addr <= '0;
      or_rd_data <= '0;
      head_we    <= 1'b0;
    end else if (i_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      or_valid <= 1'b0;
      or_stall <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + PTRW'(push_en);
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      or_valid <= (count_nxt != '0);
      or_stall <= (count_nxt == CNTW'(DEPTH));
      if (load_head) begin
        if (head_from_push) begin
          or_rd_addr <= i_rd_addr;
          or_rd_data <= push_data;
          head_we    <= push_we;
        end else begin
          or_rd_addr <= buf_addr[rd_ptr_nxt];
          or_rd_data <= buf_data[rd_ptr_nxt];
          head_we    <= buf_we[rd_ptr_nxt];
        end
      end
    end
  end

  assign or_rd_write = head_we && or_valid;

`ifdef WB_INSTRET_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      or_instret <= '0;
    end else if (pop_en) begin
      or_instret <= or_instret + 64'd1;
    end
  end
`endif

endmodule
